gf180mcu_fd_sc_mcu9t5v0__dffnq_bist: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu9t5v0__bist_pkg.sv | 27 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__bist_lfsr16.sv | 23 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__dffnq_bist.sv | 171 +++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffnq_bist.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_pkg.sv
// Shared definitions for the falling-edge flop BIST wrapper: FSM state
// encoding, LFSR polynomial, default seed and the supported latency range.
package gf180mcu_fd_sc_mcu9t5v0__bist_pkg;

  // Run sequencing states; ST_ prefix keeps them clear of the DONE port name.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1 in a right-shifting register:
  // stages 16,14,13,11 map onto bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Launch-to-compare latency bounds (2 = DUT wired directly).
  localparam int MIN_LAT = 2;
  localparam int MAX_LAT = 8;

  // One LFSR step: feedback enters at the top, output bit leaves at bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_lfsr16.sv
// 16-bit Fibonacci LFSR pattern source. Updates on the falling clock edge,
// like the flop under test. rst/load reload the seed; enable advances one step.
module gf180mcu_fd_sc_mcu9t5v0__bist_lfsr16
  import gf180mcu_fd_sc_mcu9t5v0__bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  // Reload has priority over stepping so a run always starts from the seed.
  always_ff @(negedge clk) begin
    if (rst || load) begin
      state <= seed;
    end else if (enable) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffnq_bist.sv
// Stimulus/response BIST around a falling-edge D flop cell.
// An LFSR drives D_DUT. Q_DUT is compared against a LAT-deep delayed copy of
// the launched bits, and the wrapper reports a saturating error count and a
// verdict. All state changes on negedge CLKN. RST is synchronous and
// active-high.
// Optional first-error logging: define GF180MCU_FD_SC_MCU9T5V0_BIST_ERRLOG_EN
// to add the FIRST_ERR and ERRSEEN outputs.
//
// Handshake: there is no valid/ready pair. START is a level that is sampled
// only in IDLE or DONE. BUSY and DONE are registered and never high together.
// PASS is meaningful only while DONE is high and is 0 at all other times.
module gf180mcu_fd_sc_mcu9t5v0__dffnq_bist
  import gf180mcu_fd_sc_mcu9t5v0__bist_pkg::*;
#(
  parameter int          NPAT = 256,
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int          LAT  = 2,
  parameter int          ERRW = 8
) (
  input  logic            CLKN,
  input  logic            RST,
  input  logic            START,
  input  logic            Q_DUT,
  output logic            D_DUT,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [ERRW-1:0] ERRCNT,
`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRLOG_EN
  output logic [15:0]     FIRST_ERR,
  output logic [0:0]      ERRSEEN,
`endif
  output logic [1:0]      STATE_DBG
);

  // An all-zero seed would lock the LFSR, so it falls back to the default.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
  // Out-of-range latency and pattern counts are clamped to the legal range.
  localparam int LAT_C  = (LAT < MIN_LAT) ? MIN_LAT : ((LAT > MAX_LAT) ? MAX_LAT : LAT);
  localparam int NPAT_C = (NPAT < 1) ? 1 : ((NPAT > 65535) ? 65535 : NPAT);
  localparam logic [15:0]     NPAT_LAST  = 16'(NPAT_C - 1);
  localparam logic [3:0]      DRAIN_LAST = 4'(LAT_C - 1);
  localparam logic [ERRW-1:0] ERR_MAX    = {ERRW{1'b1}};

  bist_state_e      state;
  logic [15:0]      lfsr_q;
  logic [15:0]      pat_cnt;
  logic [3:0]       drn_cnt;
  logic [LAT_C-1:0] exp_pipe;
  logic [LAT_C-1:0] vld_pipe;

  logic             start_run;
  logic             launch;
  logic             lfsr_dead;
  logic             tail_vld;
  logic             tail_miss;
  logic [ERRW-1:0]  errcnt_nxt;

  // Pattern source. It reloads at run start. It also reloads if it ever reads
  // all-zero, which guards against a corrupted register.
  gf180mcu_fd_sc_mcu9t5v0__bist_lfsr16 u_lfsr (
    .clk    (CLKN),
    .rst    (RST),
    .load   (start_run || lfsr_dead),
    .enable (launch),
    .seed   (SEED_EFF),
    .state  (lfsr_q)
  );

  // Run control, tail comparison and saturating error increment.
  always_comb begin
    start_run  = 1'b0;
    launch     = 1'b0;
    lfsr_dead  = 1'b0;
    tail_vld   = 1'b0;
    tail_miss  = 1'b0;
    errcnt_nxt = ERRCNT;
    start_run  = ((state == ST_IDLE) || (state == ST_DONE)) && START;
    launch     = (state == ST_RUN);
    lfsr_dead  = (lfsr_q == 16'h0000);
    tail_vld   = vld_pipe[LAT_C-1];
    // A case-inequality compare makes an X or Z on Q_DUT count as a miss.
    tail_miss  = tail_vld && (Q_DUT !== exp_pipe[LAT_C-1]);
    if (tail_miss && (ERRCNT != ERR_MAX)) begin
      errcnt_nxt = ERRCNT + ERRW'(1);
    end
  end

  // FSM with registered outputs, plus the expected/valid pipes.
  // A bit launched at edge n reaches the pipe tail in time for the compare at
  // edge n+LAT. This edge is the one at which an ideal DUT's Q is sampled
  // LAT-1 edges after capture.
  always_ff @(negedge CLKN) begin
    if (RST) begin
      state    <= ST_IDLE;
      D_DUT    <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
      ERRCNT   <= '0;
      pat_cnt  <= '0;
      drn_cnt  <= '0;
      exp_pipe <= '0;
      vld_pipe <= '0;
    end else begin
      exp_pipe <= {exp_pipe[LAT_C-2:0], lfsr_q[0]};
      vld_pipe <= {vld_pipe[LAT_C-2:0], launch};
      ERRCNT   <= errcnt_nxt;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_run) begin
            state    <= ST_RUN;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
            ERRCNT   <= '0;
            pat_cnt  <= '0;
            drn_cnt  <= '0;
            exp_pipe <= '0;
            vld_pipe <= '0;
          end
        end
        ST_RUN: begin
          D_DUT   <= lfsr_q[0];
          pat_cnt <= pat_cnt + 16'd1;
          if (pat_cnt == NPAT_LAST) begin
            state   <= ST_DRAIN;
            drn_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          // D_DUT holds its last launched value while the pipe empties.
          if (drn_cnt == DRAIN_LAST) begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            // The final compare lands on this edge, so it uses the next count.
            PASS  <= (errcnt_nxt == '0);
          end else begin
            drn_cnt <= drn_cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign STATE_DBG = state;

`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRLOG_EN
  logic [15:0] cmp_idx;

  // Index of the compared pattern; the first miss in a run is latched.
  always_ff @(negedge CLKN) begin
    if (RST || start_run) begin
      cmp_idx   <= '0;
      FIRST_ERR <= '0;
      ERRSEEN   <= 1'b0;
    end else if (tail_vld) begin
      cmp_idx <= cmp_idx + 16'd1;
      if (tail_miss && !ERRSEEN[0]) begin
        FIRST_ERR <= cmp_idx;
        ERRSEEN   <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffnq_bist.sv
// Bench for the falling-edge flop BIST wrapper. Several instances cover the
// different parameter sets, each with a behavioural DUT flop model.
module tb_gf180mcu_fd_sc_mcu9t5v0__dffnq_bist;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [0:0] exp_q[$];
  logic       gold [0:255];
  int         ones256;

  // Instance a: NPAT=16, LAT=2, ideal DUT with an optional bit flip.
  logic rst_a = 1'b1, start_a = 1'b0, flip_a = 1'b0, q_a = 1'b0;
  logic d_a, busy_a, done_a, pass_a;
  logic [7:0] err_a;
  logic [1:0] st_a;
  // Group g: instances b..e share reset and start.
  logic rst_g = 1'b1, start_g = 1'b0, q_zero = 1'b0;
  logic d_b, busy_b, done_b, pass_b; logic [7:0] err_b; logic [1:0] st_b;
  logic d_c, busy_c, done_c, pass_c; logic [3:0] err_c; logic [1:0] st_c;
  logic d_d, busy_d, done_d, pass_d; logic [7:0] err_d; logic [1:0] st_d;
  logic d_e, busy_e, done_e, pass_e; logic [7:0] err_e; logic [1:0] st_e;
  logic d1 = 1'b0, q_d = 1'b0, e1 = 1'b0, q_e = 1'b0;
`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRLOG_EN
  logic [15:0] fe_a, fe_b, fe_c, fe_d, fe_e;
  logic [0:0]  es_a, es_b, es_c, es_d, es_e;
`endif

  // Falling-edge DUT flop models: a single flop for a, and two stages for d/e.
  always @(negedge clk) begin
    q_a <= d_a ^ flip_a;
    d1  <= d_d;
    q_d <= d1;
    e1  <= d_e;
    q_e <= e1;
  end

  gf180mcu_fd_sc_mcu9t5v0__dffnq_bist #(.NPAT(16), .SEED(16'hACE1), .LAT(2), .ERRW(8)) u_a (
    .CLKN(clk), .RST(rst_a), .START(start_a), .Q_DUT(q_a), .D_DUT(d_a),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERRCNT(err_a),
`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRLOG_EN
    .FIRST_ERR(fe_a), .ERRSEEN(es_a),
`endif
    .STATE_DBG(st_a));

  gf180mcu_fd_sc_mcu9t5v0__dffnq_bist #(.NPAT(256), .SEED(16'hACE1), .LAT(2), .ERRW(8)) u_b (
    .CLKN(clk), .RST(rst_g), .START(start_g), .Q_DUT(q_zero), .D_DUT(d_b),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERRCNT(err_b),
`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRLOG_EN
    .FIRST_ERR(fe_b), .ERRSEEN(es_b),
`endif
    .STATE_DBG(st_b));

  gf180mcu_fd_sc_mcu9t5v0__dffnq_bist #(.NPAT(256), .SEED(16'hACE1), .LAT(2), .ERRW(4)) u_c (
    .CLKN(clk), .RST(rst_g), .START(start_g), .Q_DUT(q_zero), .D_DUT(d_c),
    .BUSY(busy_c), .DONE(done_c), .PASS(pass_c), .ERRCNT(err_c),
`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRLOG_EN
    .FIRST_ERR(fe_c), .ERRSEEN(es_c),
`endif
    .STATE_DBG(st_c));

  gf180mcu_fd_sc_mcu9t5v0__dffnq_bist #(.NPAT(16), .SEED(16'hACE1), .LAT(3), .ERRW(8)) u_d (
    .CLKN(clk), .RST(rst_g), .START(start_g), .Q_DUT(q_d), .D_DUT(d_d),
    .BUSY(busy_d), .DONE(done_d), .PASS(pass_d), .ERRCNT(err_d),
`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRLOG_EN
    .FIRST_ERR(fe_d), .ERRSEEN(es_d),
`endif
    .STATE_DBG(st_d));

  gf180mcu_fd_sc_mcu9t5v0__dffnq_bist #(.NPAT(16), .SEED(16'hACE1), .LAT(2), .ERRW(8)) u_e (
    .CLKN(clk), .RST(rst_g), .START(start_g), .Q_DUT(q_e), .D_DUT(d_e),
    .BUSY(busy_e), .DONE(done_e), .PASS(pass_e), .ERRCNT(err_e),
`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRLOG_EN
    .FIRST_ERR(fe_e), .ERRSEEN(es_e),
`endif
    .STATE_DBG(st_e));

  // ---------------- scoreboard check ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver: one run on instance a ----------------
  // Posedge k lies between DUT edges s+k-1 and s+k, where s is the START sample edge.
  task automatic run_a(input int flip_k, input int rst_k, input bit chk_d, input int budget,
                       output int busy_cnt, output int done_seen);
    logic [0:0] e;
    start_a = 1'b1;
    @(posedge clk);
    start_a = 1'b0;
    busy_cnt  = 0;
    done_seen = 0;
    for (int k = 1; k <= budget; k++) begin
      flip_a = (k == flip_k);
      rst_a  = (k == rst_k);
      if (chk_d && k >= 2 && k <= 17 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq($sformatf("d_dut_p%0d", k - 2), 32'(d_a), 32'(e));
      end
      if (rst_k > 0 && k == rst_k) begin
        check_eq("pre_rst_busy", 32'(busy_a), 32'd1);
        check_eq("pre_rst_err", 32'(err_a), 32'd1);
      end
      if (rst_k > 0 && k == rst_k + 1) begin
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_pass", 32'(pass_a), 32'd0);
        check_eq("rst_err", 32'(err_a), 32'd0);
        check_eq("rst_d", 32'(d_a), 32'd0);
        check_eq("rst_state", 32'(st_a), 32'd0);
`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRLOG_EN
        check_eq("rst_errseen", 32'(es_a), 32'd0);
        check_eq("rst_first_err", 32'(fe_a), 32'd0);
`endif
      end
      if (busy_a && done_a) check_eq("busy_done_excl", 32'd1, 32'd0);
      if (busy_a) busy_cnt++;
      if (done_a) begin
        done_seen = 1;
        break;
      end
      @(posedge clk);
    end
    flip_a = 1'b0;
    rst_a  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s;
    int bc, ds, dcnt, seen;

    // Golden LFSR stream from seed ACE1.
    s = 16'hACE1;
    ones256 = 0;
    for (int i = 0; i < 256; i++) begin
      gold[i] = s[0];
      if (s[0]) ones256++;
      s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    end

    // Reset state.
    repeat (3) @(posedge clk);
    check_eq("reset_busy", 32'(busy_a), 32'd0);
    check_eq("reset_done", 32'(done_a), 32'd0);
    check_eq("reset_pass", 32'(pass_a), 32'd0);
    check_eq("reset_err", 32'(err_a), 32'd0);
    check_eq("reset_d", 32'(d_a), 32'd0);
    check_eq("reset_state", 32'(st_a), 32'd0);
    rst_a = 1'b0;
    rst_g = 1'b0;
    repeat (2) @(posedge clk);
    check_eq("idle_hold_state", 32'(st_a), 32'd0);

    // T1: ideal DUT, NPAT=16, LAT=2.
    for (int i = 0; i < 16; i++) exp_q.push_back(gold[i]);
    run_a(0, 0, 1'b1, 40, bc, ds);
    check_eq("t1_done_seen", 32'(ds), 32'd1);
    check_eq("t1_busy_cycles", 32'(bc), 32'd18);
    check_eq("t1_d_all_checked", 32'(exp_q.size()), 32'd0);
    check_eq("t1_pass", 32'(pass_a), 32'd1);
    check_eq("t1_err", 32'(err_a), 32'd0);
    check_eq("t1_state", 32'(st_a), 32'd3);
    check_eq("t1_d_held", 32'(d_a), 32'(gold[15]));
    @(posedge clk);
    check_eq("t1_done_hold", 32'(done_a), 32'd1);

    // T2: flip only pattern index 5 (captured at edge s+7).
    run_a(7, 0, 1'b0, 40, bc, ds);
    check_eq("t2_done_seen", 32'(ds), 32'd1);
    check_eq("t2_busy_cycles", 32'(bc), 32'd18);
    check_eq("t2_err", 32'(err_a), 32'd1);
    check_eq("t2_pass", 32'(pass_a), 32'd0);
`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRLOG_EN
    check_eq("t2_first_err", 32'(fe_a), 32'd5);
    check_eq("t2_errseen", 32'(es_a), 32'd1);
`endif

    // T3: START held high; the count clears at restart and DONE lasts one cycle.
    start_a = 1'b1;
    @(posedge clk);
    check_eq("t3_restart_busy", 32'(busy_a), 32'd1);
    check_eq("t3_restart_err_clr", 32'(err_a), 32'd0);
    check_eq("t3_restart_pass_low", 32'(pass_a), 32'd0);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (done_a) begin
        seen = 1;
        break;
      end
      @(posedge clk);
    end
    check_eq("t3_done_seen", 32'(seen), 32'd1);
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (done_a) dcnt++;
      if (busy_a) break;
      @(posedge clk);
    end
    check_eq("t3_done_one_cycle", 32'(dcnt), 32'd1);
    check_eq("t3_rerun_busy", 32'(busy_a), 32'd1);
    start_a = 1'b0;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (done_a) begin
        seen = 1;
        break;
      end
      @(posedge clk);
    end
    check_eq("t3_final_done", 32'(seen), 32'd1);
    check_eq("t3_final_pass", 32'(pass_a), 32'd1);

    // T4: a miss at index 1, then RST at launch 7 (edge s+8); no DONE follows.
    run_a(3, 8, 1'b0, 40, bc, ds);
    check_eq("t4_no_done", 32'(ds), 32'd0);
    check_eq("t4_idle", 32'(st_a), 32'd0);

    // T5: stuck-at-0 (NPAT=256; ERRW=8 and ERRW=4) and LAT=3 vs LAT=2 with a two-flop DUT.
    start_g = 1'b1;
    @(posedge clk);
    start_g = 1'b0;
    seen = 0;
    for (int k = 0; k < 400; k++) begin
      if (done_b) begin
        seen = 1;
        break;
      end
      @(posedge clk);
    end
    check_eq("t5_done_b", 32'(seen), 32'd1);
    check_eq("t5_stuck0_err", 32'(err_b), 32'(ones256));
    check_eq("t5_stuck0_pass", 32'(pass_b), 32'd0);
    check_eq("t5_sat_done", 32'(done_c), 32'd1);
    check_eq("t5_sat_err", 32'(err_c), 32'd15);
    check_eq("t5_sat_pass", 32'(pass_c), 32'd0);
    check_eq("t5_lat3_done", 32'(done_d), 32'd1);
    check_eq("t5_lat3_pass", 32'(pass_d), 32'd1);
    check_eq("t5_lat3_err", 32'(err_d), 32'd0);
    check_eq("t5_lat2_retimed_done", 32'(done_e), 32'd1);
    check_eq("t5_lat2_retimed_pass", 32'(pass_e), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
